// File: rtl/ps2_rx_fifo_pkg.sv
// PS/2 receiver shared definitions: frame layout and FSM state codes.
package ps2_rx_fifo_pkg;

    localparam int FRAME_BITS = 11;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam logic ODD_PARITY = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RX = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Show-ahead synchronous FIFO; a push while full is accepted only
// when a pop happens in the same cycle.
module ps2_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_empty,
    output logic             o_full,
    output logic [AW:0]      o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0] r_cnt;
    logic w_wr;
    logic w_rd;

    assign o_empty = (r_cnt == '0);
    assign o_full = (r_cnt == (AW+1)'(DEPTH));
    assign o_count = r_cnt;
    assign w_rd = i_pop & ~o_empty;
    assign w_wr = i_push & (~o_full | w_rd);
    assign o_dout = o_empty ? '0 : r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= i_din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            case ({w_wr, w_rd})
                2'b10: r_cnt <= r_cnt + 1'b1;
                2'b01: r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver with glitch filter, frame checking,
// inter-bit watchdog and a scan-code FIFO.
module ps2_rx_fifo
    import ps2_rx_fifo_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH = 8,
    parameter int AW = $clog2(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ps2d,
    input  logic          ps2c,
    input  logic          rx_en,
    input  logic          rd_en,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          rx_done_tick,
    output logic          err_tick,
    output logic [2:0]    err_status,
    input  logic          clr_err
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC - 1);

    logic [FILTER_LEN-1:0] r_filt;
    logic [FILTER_LEN-1:0] w_filt_next;
    logic r_fclk;
    logic w_fclk_next;
    logic w_fall;

    logic [1:0] r_state;
    logic [3:0] r_bitcnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic [TW-1:0] r_tmo;

    logic w_chk;
    logic w_frame_ok;
    logic w_par_ok;
    logic w_good;
    logic w_pop;
    logic w_push;
    logic w_tmo_hit;
    logic [2:0] w_err_new;
    logic r_done;
    logic r_err_tick;
    logic [2:0] r_err;

    assign w_filt_next = {ps2c, r_filt[FILTER_LEN-1:1]};

    always_comb begin
        w_fclk_next = r_fclk;
        if (&w_filt_next) w_fclk_next = 1'b1;
        else if (~|w_filt_next) w_fclk_next = 1'b0;
    end

    assign w_fall = r_fclk & ~w_fclk_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_filt <= '1;
            r_fclk <= 1'b1;
        end else begin
            r_filt <= w_filt_next;
            r_fclk <= w_fclk_next;
        end
    end

    assign w_tmo_hit = (r_state == ST_RX) & ~w_fall & (r_tmo == TMO_MAX);

    // Start bit is captured on the IDLE edge, so RX counts the other ten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift <= '0;
            r_tmo <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fall && rx_en) begin
                        r_shift <= {ps2d, r_shift[FRAME_BITS-1:1]};
                        r_bitcnt <= 4'd9;
                        r_tmo <= '0;
                        r_state <= ST_RX;
                    end
                end
                ST_RX: begin
                    if (w_fall) begin
                        r_shift <= {ps2d, r_shift[FRAME_BITS-1:1]};
                        r_tmo <= '0;
                        if (r_bitcnt == 4'd0) r_state <= ST_CHECK;
                        else r_bitcnt <= r_bitcnt - 4'd1;
                    end else if (w_tmo_hit) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_CHECK: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_chk = (r_state == ST_CHECK);
    assign w_frame_ok = (r_shift[0] == START_BIT) &
                        (r_shift[FRAME_BITS-1] == STOP_BIT);
    assign w_par_ok = ((^r_shift[9:1]) == ODD_PARITY);
    assign w_good = w_chk & w_frame_ok & w_par_ok;
    assign w_pop = rd_en & ~empty;
    assign w_push = w_good & (~full | w_pop);

    assign w_err_new = {w_good & full & ~w_pop,
                        (w_chk & ~w_frame_ok) | w_tmo_hit,
                        w_chk & w_frame_ok & ~w_par_ok};

    // A clear and a fresh error in the same cycle leave the new bit set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
            r_err_tick <= 1'b0;
            r_err <= '0;
        end else begin
            r_done <= w_push;
            r_err_tick <= |w_err_new;
            r_err <= (clr_err ? 3'b000 : r_err) | w_err_new;
        end
    end

    ps2_sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .reset(reset),
        .i_push(w_push),
        .i_pop(w_pop),
        .i_din(r_shift[8:1]),
        .o_dout(dout),
        .o_empty(empty),
        .o_full(full),
        .o_count(count)
    );

    assign busy = (r_state != ST_IDLE);
    assign rx_done_tick = r_done;
    assign err_tick = r_err_tick;
    assign err_status = r_err;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are driven bit by bit and
// expected scan codes are queued, then popped as the FIFO is read.
module tb_ps2_rx_fifo;

    localparam int FL = 4;
    localparam int TMO = 200;
    localparam int DEPTH = 4;
    localparam int AW = $clog2(DEPTH);
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset;
    logic ps2d;
    logic ps2c;
    logic rx_en;
    logic rd_en;
    logic [7:0] dout;
    logic empty;
    logic full;
    logic [AW:0] count;
    logic busy;
    logic rx_done_tick;
    logic err_tick;
    logic [2:0] err_status;
    logic clr_err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    ps2_rx_fifo #(
        .FILTER_LEN(FL),
        .TIMEOUT_CYC(TMO),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ps2d(ps2d),
        .ps2c(ps2c),
        .rx_en(rx_en),
        .rd_en(rd_en),
        .dout(dout),
        .empty(empty),
        .full(full),
        .count(count),
        .busy(busy),
        .rx_done_tick(rx_done_tick),
        .err_tick(err_tick),
        .err_status(err_status),
        .clr_err(clr_err)
    );

    always @(negedge clk) begin
        if (rx_done_tick) done_cnt++;
        if (err_tick) err_cnt++;
    end

    task automatic send_frame(input logic [7:0] d, input logic par_bad,
                              input logic stop, input int nbits,
                              input logic drop_en, input logic good);
        logic [10:0] f;
        f = {stop, (~^d) ^ par_bad, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2d = f[i];
            repeat (HALF) @(negedge clk);
            ps2c = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2c = 1'b1;
            if (i == 0 && drop_en) rx_en = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ps2d = 1'b1;
        if (good && exp_q.size() < DEPTH) exp_q.push_back(d);
    endtask

    task automatic read_one(input string nm);
        logic [7:0] e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL %s: read requested but scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            if (empty !== 1'b0 || dout !== e) begin
                n_errors++;
                $display("FAIL %s: dout=%h empty=%b want dout=%h empty=0",
                         nm, dout, empty, e);
            end
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic chk_state(input string nm, input logic [AW:0] c,
                             input logic [2:0] es, input logic b);
        n_checks++;
        if (count !== c || err_status !== es || busy !== b) begin
            n_errors++;
            $display("FAIL %s: count=%0d err=%b busy=%b want %0d %b %b",
                     nm, count, err_status, busy, c, es, b);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0 || dout !== 8'h00 ||
            rx_done_tick !== 1'b0 || err_tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: empty=%b full=%b dout=%h done=%b et=%b",
                     empty, full, dout, rx_done_tick, err_tick);
        end
        chk_state("reset_state", 0, 3'b000, 1'b0);
    endtask

    task automatic test_good();
        int d0;
        d0 = done_cnt;
        send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        n_checks++;
        if (done_cnt - d0 !== 1 || empty !== 1'b0) begin
            n_errors++;
            $display("FAIL good_done: ticks=%0d empty=%b want 1 0",
                     done_cnt - d0, empty);
        end
        chk_state("good_count", 1, 3'b000, 1'b0);
        read_one("good_data");
        chk_state("good_drained", 0, 3'b000, 1'b0);
    endtask

    task automatic test_parity();
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0, 1'b0);
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_errors++;
            $display("FAIL parity_tick: ticks=%0d want 1", err_cnt - e0);
        end
        chk_state("parity_status", 0, 3'b001, 1'b0);
        do_clr();
    endtask

    task automatic test_stop();
        int e0;
        e0 = err_cnt;
        send_frame(8'h33, 1'b0, 1'b0, 11, 1'b0, 1'b0);
        n_checks++;
        if (err_cnt - e0 !== 1 || empty !== 1'b1) begin
            n_errors++;
            $display("FAIL stop_tick: ticks=%0d empty=%b want 1 1",
                     err_cnt - e0, empty);
        end
        chk_state("stop_status", 0, 3'b010, 1'b0);
        do_clr();
        chk_state("stop_cleared", 0, 3'b000, 1'b0);
    endtask

    task automatic test_timeout();
        int e0;
        e0 = err_cnt;
        send_frame(8'h00, 1'b0, 1'b1, 5, 1'b0, 1'b0);
        chk_state("tmo_busy_mid", 0, 3'b000, 1'b1);
        repeat (TMO + 20) @(negedge clk);
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_errors++;
            $display("FAIL tmo_tick: ticks=%0d want 1", err_cnt - e0);
        end
        chk_state("tmo_status", 0, 3'b010, 1'b0);
        do_clr();
        send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        chk_state("tmo_next", 1, 3'b000, 1'b0);
        read_one("tmo_next_data");
    endtask

    task automatic test_rx_en();
        int d0;
        d0 = done_cnt;
        rx_en = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b0, 1'b0);
        chk_state("rxen_off", 0, 3'b000, 1'b0);
        rx_en = 1'b1;
        send_frame(8'hE7, 1'b0, 1'b1, 11, 1'b1, 1'b1);
        rx_en = 1'b1;
        n_checks++;
        if (done_cnt - d0 !== 1) begin
            n_errors++;
            $display("FAIL rxen_drop: ticks=%0d want 1", done_cnt - d0);
        end
        read_one("rxen_drop_data");
    endtask

    task automatic test_overflow();
        int e0;
        e0 = err_cnt;
        for (int i = 0; i <= DEPTH; i++)
            send_frame(8'h10 + 8'(i * 37), 1'b0, 1'b1, 11, 1'b0, 1'b1);
        n_checks++;
        if (full !== 1'b1 || err_cnt - e0 !== 1) begin
            n_errors++;
            $display("FAIL ovf_full: full=%b ticks=%0d want 1 1",
                     full, err_cnt - e0);
        end
        chk_state("ovf_status", (AW+1)'(DEPTH), 3'b100, 1'b0);
        for (int i = 0; i < DEPTH; i++) read_one("ovf_order");
        n_checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_drain: empty=%b full=%b want 1 0",
                     empty, full);
        end
        do_clr();
    endtask

    task automatic test_glitch();
        int d0;
        d0 = done_cnt;
        ps2d = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ps2c = 1'b0;
            repeat (FL - 1) @(negedge clk);
            ps2c = 1'b1;
            repeat (FL + 1) @(negedge clk);
            chk_state("glitch_idle", 0, 3'b000, 1'b0);
        end
        ps2d = 1'b1;
        n_checks++;
        if (done_cnt !== d0) begin
            n_errors++;
            $display("FAIL glitch_done: ticks=%0d want 0", done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h21, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        send_frame(8'h77, 1'b0, 1'b1, 4, 1'b0, 1'b0);
        chk_state("mid_before", 1, 3'b000, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk_state("mid_after", 0, 3'b000, 1'b0);
        send_frame(8'h4B, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        chk_state("mid_next", 1, 3'b000, 1'b0);
        read_one("mid_next_data");
    endtask

    task automatic test_back_to_back();
        send_frame(8'h01, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        send_frame(8'h80, 1'b0, 1'b1, 11, 1'b0, 1'b1);
        chk_state("b2b_count", 3, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) read_one("b2b_data");
    endtask

    initial begin
        reset = 1'b1;
        ps2d = 1'b1;
        ps2c = 1'b1;
        rx_en = 1'b1;
        rd_en = 1'b0;
        clr_err = 1'b0;
        test_reset();
        test_good();
        test_parity();
        test_stop();
        test_timeout();
        test_rx_en();
        test_overflow();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
